// File: rtl/user_seq_checker.sv
`default_nettype none
// ============================================================================
// Module      : user_seq_checker
// Description : Player-side sequence checker for the Genius game. Counts the
//               player's button presses and compares each press against the
//               stored colour at the current sequence position. Reports round
//               completion (end_User / win) or a wrong entry (fail).
// Ports       : clk        - system clock, rising edge
//               R          - asynchronous active-low reset
//               E          - start-of-player-phase pulse
//               data       - index of the last colour of the round
//               btn        - one-hot debounced buttons, level-high while held
//               seq_color  - expected colour at address SEQUSER (same cycle)
//               SEQUSER    - current player index / memory read address
//               end_User   - one-cycle pulse on a correctly completed round
//               win        - level, last round completed correctly
//               fail       - level, wrong colour entered
//               busy       - high while waiting for a press or a release
//               timeout    - (USER_TIMEOUT_EN only) level, fail caused by
//                            player inactivity
// Options     : define USER_TIMEOUT_EN to add the inactivity timeout
//               (parameter TIMEOUT_CYCLES, output timeout).
// Revision    : 1.0 - initial release
// ============================================================================
module user_seq_checker #(
    parameter int SIZE = 4
`ifdef USER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 50_000_000
`endif
) (
    input  logic            clk,
    input  logic            R,
    input  logic            E,
    input  logic [SIZE-1:0] data,
    input  logic [3:0]      btn,
    input  logic [1:0]      seq_color,
    output logic [SIZE-1:0] SEQUSER,
    output logic            end_User,
    output logic            win,
    output logic            fail,
    output logic            busy
`ifdef USER_TIMEOUT_EN
    ,
    output logic            timeout
`endif
);

    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_WAIT_PRESS   = 2'd1,
        S_WAIT_RELEASE = 2'd2,
        S_DONE         = 2'd3
    } state_t;

    localparam logic [SIZE-1:0] ONE = {{(SIZE-1){1'b0}}, 1'b1};

    state_t          state_q, state_d;
    logic [SIZE-1:0] seq_q,   seq_d;
    logic [SIZE-1:0] data_q,  data_d;
    logic [3:0]      btn_q;
    logic            win_q,   win_d;
    logic            fail_q,  fail_d;
    logic            end_q,   end_d;

    logic            press_w;
    logic            onehot_w;
    logic [1:0]      color_w;
    logic            match_w;

`ifdef USER_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             to_q,  to_d;
`endif

    // A press is the first cycle any button is seen after all were released.
    assign press_w = (btn != 4'b0000) && (btn_q == 4'b0000);

    always_comb begin
        onehot_w = 1'b1;
        color_w  = 2'd0;
        case (btn)
            4'b0001: color_w = 2'd0;
            4'b0010: color_w = 2'd1;
            4'b0100: color_w = 2'd2;
            4'b1000: color_w = 2'd3;
            default: onehot_w = 1'b0;
        endcase
    end

    // Multi-button or empty codes never match, even if the decode aliases.
    assign match_w = onehot_w && (color_w == seq_color);

    always_comb begin
        state_d = state_q;
        seq_d   = seq_q;
        data_d  = data_q;
        win_d   = win_q;
        fail_d  = fail_q;
        end_d   = 1'b0;
`ifdef USER_TIMEOUT_EN
        cnt_d   = cnt_q;
        to_d    = to_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (E) begin
                    data_d  = data;
                    seq_d   = '0;
                    win_d   = 1'b0;
                    fail_d  = 1'b0;
                    state_d = S_WAIT_PRESS;
`ifdef USER_TIMEOUT_EN
                    cnt_d   = '0;
                    to_d    = 1'b0;
`endif
                end
            end
            S_WAIT_PRESS: begin
                if (press_w) begin
`ifdef USER_TIMEOUT_EN
                    cnt_d = '0;
`endif
                    if (!match_w) begin
                        fail_d  = 1'b1;
                        state_d = S_DONE;
                    end else if (seq_q == data_q) begin
                        end_d   = 1'b1;
                        win_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        seq_d   = seq_q + ONE;
                        state_d = S_WAIT_RELEASE;
                    end
                end
`ifdef USER_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    fail_d  = 1'b1;
                    to_d    = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_WAIT_RELEASE: begin
                if (btn == 4'b0000) begin
                    state_d = S_WAIT_PRESS;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            state_q <= S_IDLE;
            seq_q   <= '0;
            data_q  <= '0;
            btn_q   <= 4'b0000;
            win_q   <= 1'b0;
            fail_q  <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            data_q  <= data_d;
            btn_q   <= btn;
            win_q   <= win_d;
            fail_q  <= fail_d;
            end_q   <= end_d;
        end
    end

`ifdef USER_TIMEOUT_EN
    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end

    assign timeout = to_q;
`endif

    assign SEQUSER  = seq_q;
    assign end_User = end_q;
    assign win      = win_q;
    assign fail     = fail_q;
    assign busy     = (state_q == S_WAIT_PRESS) || (state_q == S_WAIT_RELEASE);

endmodule
`default_nettype wire

// File: tb/tb_user_seq_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_user_seq_checker
// Description : Directed self-checking bench for user_seq_checker (default
//               build, timeout feature disabled).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_user_seq_checker;

    localparam int SIZE = 4;

    logic            clk;
    logic            R;
    logic            E;
    logic [SIZE-1:0] data;
    logic [3:0]      btn;
    logic [1:0]      seq_color;
    logic [SIZE-1:0] SEQUSER;
    logic            end_User;
    logic            win;
    logic            fail;
    logic            busy;

    logic [1:0]      seq_mem [0:15];

    int              total;
    int              bad;
    int              end_cnt;

    user_seq_checker #(.SIZE(SIZE)) dut (
        .clk       (clk),
        .R         (R),
        .E         (E),
        .data      (data),
        .btn       (btn),
        .seq_color (seq_color),
        .SEQUSER   (SEQUSER),
        .end_User  (end_User),
        .win       (win),
        .fail      (fail),
        .busy      (busy)
    );

    // Sequence memory: combinational read at the player index.
    assign seq_color = seq_mem[SEQUSER];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_round(input logic [SIZE-1:0] d);
        data = d;
        E    = 1'b1;
        tick(1);
        E    = 1'b0;
    endtask

    // Press and hold for one edge, then release for one edge.
    task automatic press(input logic [3:0] b);
        btn = b;
        tick(1);
    endtask

    task automatic release_btn();
        btn = 4'b0000;
        tick(1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        E     = 1'b0;
        data  = '0;
        btn   = 4'b0000;
        for (int i = 0; i < 16; i++) seq_mem[i] = 2'd0;

        // ---------------- reset ----------------
        R = 1'b1;
        #3 R = 1'b0;
        #20;
        chk("rst_sequser", SEQUSER, 0);
        chk("rst_flags", {end_User, win, fail, busy}, 4'b0000);
        @(posedge clk); #1;
        R = 1'b1;
        tick(1);

        // Presses without E are ignored.
        press(4'b0100);
        release_btn();
        chk("noE_busy", busy, 0);
        chk("noE_sequser_fail", {SEQUSER, fail, win}, 0);

        // ---------------- full correct round ----------------
        seq_mem[0] = 2'd2; seq_mem[1] = 2'd0; seq_mem[2] = 2'd3; seq_mem[3] = 2'd1;
        start_round(4'd3);
        chk("start_busy", busy, 1);
        chk("start_sequser", SEQUSER, 0);
        begin
            logic [3:0] seq_btn [0:3];
            seq_btn[0] = 4'b0100; seq_btn[1] = 4'b0001;
            seq_btn[2] = 4'b1000; seq_btn[3] = 4'b0010;
            for (int i = 0; i < 4; i++) begin
                press(seq_btn[i]);
                if (i < 3) begin
                    chk("round_step", {SEQUSER, end_User, win, fail}, {4'(i + 1), 3'b000});
                    release_btn();
                end else begin
                    chk("round_last", {SEQUSER, end_User, win, fail}, {4'd3, 3'b110});
                end
            end
        end
        release_btn();
        chk("round_end_pulse", {end_User, win, fail, busy}, 4'b0100);
        chk("round_hold_idx", SEQUSER, 3);

        // ---------------- wrong colour ----------------
        start_round(4'd3);
        chk("restart_clear", {SEQUSER, win, fail, busy}, {4'd0, 3'b001});
        press(4'b0100);
        release_btn();
        btn = 4'b0010;
        chk("wrong_pre", fail, 0);
        tick(1);
        chk("wrong_fail", {SEQUSER, end_User, win, fail}, {4'd1, 3'b001});
        release_btn();
        chk("wrong_done", {busy, fail}, 2'b01);

        // ---------------- hold / multi-press ----------------
        start_round(4'd3);
        btn = 4'b0100;
        tick(10);
        chk("hold_once", {SEQUSER, fail}, {4'd1, 1'b0});
        E = 1'b1;
        tick(1);
        E = 1'b0;
        chk("E_ignored", {SEQUSER, busy}, {4'd1, 1'b1});
        btn = 4'b1100;
        tick(3);
        chk("multi_ignored", {SEQUSER, fail, win}, {4'd1, 2'b00});
        release_btn();
        press(4'b0101);
        chk("nononehot_fail", {SEQUSER, fail, win, end_User}, {4'd1, 3'b100});
        release_btn();

        // ---------------- max length, data change mid-round ----------------
        for (int i = 0; i < 16; i++) seq_mem[i] = 2'((i * 3 + 1) % 4);
        start_round(4'd15);
        end_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            logic [3:0] b;
            b = 4'b0001 << seq_mem[i];
            if (i == 5) data = 4'd2;
            press(b);
            if (end_User) end_cnt++;
            if (i == 14) chk("max_pre_last", {SEQUSER, win}, {4'd15, 1'b0});
            release_btn();
        end
        chk("max_end_once", end_cnt, 1);
        chk("max_final", {SEQUSER, win, fail}, {4'd15, 2'b10});

        // ---------------- reset mid-round ----------------
        seq_mem[0] = 2'd2; seq_mem[1] = 2'd0;
        start_round(4'd3);
        press(4'b0100);
        release_btn();
        chk("mid_pre", SEQUSER, 1);
        #2 R = 1'b0;
        #1;
        chk("mid_rst_async", {SEQUSER, end_User, win, fail, busy}, 0);
        @(posedge clk); #1;
        R = 1'b1;
        tick(1);
        press(4'b0100);
        release_btn();
        chk("mid_needE", {SEQUSER, busy, fail, win}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/user_seq_checker.md
Name: user_seq_checker

Overview:
- Player-side counterpart of the FPGA sequence counter in the Genius game: the FPGA side plays a sequence, this block reads it back from the player.
- Counts the player's button presses and compares each press against the stored colour at the current position.
- Reports round completion or failure to the game controller.
- Sits between the debounced button inputs, the sequence colour memory and the top-level game FSM.

Parameters:
- SIZE, 4, width of the sequence index and round-length input (max round length 2^SIZE).

Ports:
- clk  input  1  system clock, rising edge.
- R  input  1  asynchronous active-low reset; 0 resets all state immediately.
- E  input  1  start-of-player-phase pulse from the game FSM.
- data  input  SIZE  index of the last colour of the current round (round length = data+1).
- btn  input  4  one-hot player buttons, already synchronised and debounced, level-high while held.
- seq_color  input  2  expected colour code at address SEQUSER; combinational, valid the same cycle.
- SEQUSER  output  SIZE  current player index, also the sequence memory read address.
- end_User  output  1  one-cycle pulse when the full round is entered correctly.
- win  output  1  level: last round entered correctly.
- fail  output  1  level: wrong colour entered.
- busy  output  1  high while in WAIT_PRESS or WAIT_RELEASE.

Behaviour:
- Reset (R=0, async): state IDLE; SEQUSER=0; end_User=0; win=0; fail=0; busy=0; data_q=0; btn_q=0.
- btn_q registers btn every cycle.
- Press event = (btn != 0) && (btn_q == 0).
- Colour decode: btn 0001->0, 0010->1, 0100->2, 1000->3.
- Any non-one-hot value at a press event is a mismatch.
- States: IDLE, WAIT_PRESS, WAIT_RELEASE, DONE.
- IDLE: on E=1, latch data into data_q, clear SEQUSER/win/fail, go to WAIT_PRESS. busy=1 from the next cycle.
- WAIT_PRESS, press event, colour == seq_color, SEQUSER == data_q: end_User=1 for 1 cycle, win=1, go to DONE. SEQUSER holds.
- WAIT_PRESS, press event, colour == seq_color, SEQUSER < data_q: SEQUSER+1, go to WAIT_RELEASE.
- WAIT_PRESS, press event, mismatch: fail=1, go to DONE. SEQUSER holds the failing index.
- WAIT_RELEASE: stay until btn == 0, then go to WAIT_PRESS. New presses while any button is held are ignored.
- DONE: win/fail hold. On E=1, restart exactly as from IDLE (clear flags, relatch data).
- E in WAIT_PRESS/WAIT_RELEASE is ignored.
- Latency: decision registered 1 cycle after the press-event cycle.
- data changes mid-round are ignored (data_q is used).
- SEQUSER never exceeds data_q, so no wrap. data = 2^SIZE-1 is valid.
- win and fail are mutually exclusive, never both 1.
- Reset mid-round: immediate return to reset values; the next round needs E.

Optional Feature:
- Macro: USER_TIMEOUT_EN.
- When defined: parameter TIMEOUT_CYCLES (default 50_000_000) and an idle counter. The counter clears on E and on every press event, and counts while in WAIT_PRESS. On reaching TIMEOUT_CYCLES-1: fail=1, go to DONE. Extra output timeout (1 bit) is a level, set together with fail and cleared on E/reset.
- When not defined: no counter, no timeout port. WAIT_PRESS waits indefinitely.

Test Plan:
- Reset: R=0 while mid-round -> all outputs 0 immediately; state IDLE; btn presses ignored until E.
- Full correct round: data=3, sequence 2,0,3,1; E pulse; press 0100,0001,1000,0010 with releases between -> SEQUSER steps 0->1->2->3; end_User pulses once; win=1; fail=0; SEQUSER=3.
- Wrong colour: data=3, sequence 2,0,...; press 0100 then 0010 -> fail=1 one cycle after the second press event; SEQUSER=1; win=0; no end_User.
- Hold/multi-press: hold 0100 for 10 cycles, then also press 1000 while held -> counts once; second button ignored. Press 0101 from released -> fail=1.
- Max length: SIZE=4, data=15, 16 correct presses -> end_User on the 16th; SEQUSER=15; no wrap. data changed to 2 mid-round -> no effect.
- Timeout (USER_TIMEOUT_EN, TIMEOUT_CYCLES=100): E, then no press -> fail=1 and timeout=1 after 100 cycles. A press at cycle 99 restarts the count.
